// File: rtl/fetch.sv
// Instruction fetch front end: holds the PC, issues in-order word requests to the
// I-cache, captures predictor results per request and queues responses for decode.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4,
    parameter int          CNTW     = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_ic_req,
    output logic [29:0] fetch_ic_addr,
    input  logic        ic_ready,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_insn,
    input  logic        ic_resp_error,
    output logic [29:0] fetch_bp_addr,
    input  logic        bp_taken,
    input  logic [15:0] bp_tag,
    input  logic [30:0] bp_target,
    output logic        fetch_de_valid,
    output logic        fetch_de_error,
    output logic [30:0] fetch_de_addr,
    output logic [31:0] fetch_de_insn,
    output logic [15:0] fetch_de_bptag,
    output logic        fetch_de_bptaken,
    input  logic        decode_stall,
    input  logic        rob_flush,
    input  logic [30:0] rob_flush_pc
);

    localparam int              PTRW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [CNTW-1:0] QFULL = CNTW'(QDEPTH);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

    typedef struct packed {
        logic        error;
        logic [30:0] addr;
        logic [31:0] insn;
        logic [15:0] bptag;
        logic        bptaken;
    } qent_t;

    typedef struct packed {
        logic [30:0] pc;
        logic [15:0] bptag;
        logic        bptaken;
    } side_t;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_e          state_q, state_d;
    logic [30:0]     pc_q, pc_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CNTW-1:0] out_q, out_d;
    logic [CNTW-1:0] drop_q, drop_d;
    logic [PTRW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [PTRW-1:0] s_rd_q, s_rd_d, s_wr_q, s_wr_d;

    qent_t q_mem [QDEPTH];
    side_t s_mem [QDEPTH];

    qent_t       q_head;
    side_t       s_head;
    qent_t       q_wdata;
    logic        q_push;
    logic        s_push;
    logic [CNTW:0] in_use;
    logic        credit_ok;
    logic        ic_fire;
    logic        de_pop;
    logic        resp_drop;
    logic        resp_take;
    logic        misalign_push;

    assign q_head = q_mem[q_rd_q];
    assign s_head = s_mem[s_rd_q];

    // Queue entries plus requests still in flight may never exceed the queue size,
    // so every accepted response is guaranteed a slot.
    assign in_use    = {1'b0, count_q} + {1'b0, out_q};
    assign credit_ok = in_use < (CNTW + 1)'(QDEPTH);

    assign fetch_ic_req  = rst & (state_q == ST_RUN) & ~pc_q[0] & credit_ok & ~rob_flush;
    assign fetch_ic_addr = pc_q[30:1];
    assign fetch_bp_addr = pc_q[30:1];
    assign ic_fire       = fetch_ic_req & ic_ready;

    assign fetch_de_valid   = (count_q != '0);
    assign fetch_de_error   = fetch_de_valid & q_head.error;
    assign fetch_de_addr    = fetch_de_valid ? q_head.addr : '0;
    assign fetch_de_insn    = fetch_de_valid ? q_head.insn : '0;
    assign fetch_de_bptag   = fetch_de_valid ? q_head.bptag : '0;
    assign fetch_de_bptaken = fetch_de_valid & q_head.bptaken;
    assign de_pop           = fetch_de_valid & ~decode_stall;

    assign resp_drop     = ic_resp_valid & (drop_q != '0);
    assign resp_take     = ic_resp_valid & ~resp_drop;
    assign misalign_push = (state_q == ST_RUN) & pc_q[0] & (out_q == '0) &
                           (count_q != QFULL) & ~rob_flush;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        out_d   = out_q;
        drop_d  = drop_q;
        q_rd_d  = q_rd_q;
        q_wr_d  = q_wr_q;
        s_rd_d  = s_rd_q;
        s_wr_d  = s_wr_q;
        q_push  = 1'b0;
        s_push  = 1'b0;
        q_wdata = '0;

        if (rob_flush) begin
            // Everything still in flight becomes stale; a response arriving now is
            // already one of those and is discarded.
            state_d = ST_RUN;
            pc_d    = rob_flush_pc;
            count_d = '0;
            out_d   = '0;
            drop_d  = drop_q + out_q - CNTW'(ic_resp_valid);
            q_rd_d  = '0;
            q_wr_d  = '0;
            s_rd_d  = '0;
            s_wr_d  = '0;
        end else begin
            if (ic_fire) begin
                s_push = 1'b1;
                s_wr_d = ptr_inc(s_wr_q);
                pc_d   = bp_taken ? bp_target : pc_q + 31'd2;
            end

            if (resp_drop) begin
                drop_d = drop_q - 1'b1;
            end

            if (resp_take) begin
                q_push  = 1'b1;
                q_wdata = '{error: ic_resp_error, addr: s_head.pc, insn: ic_resp_insn,
                            bptag: s_head.bptag, bptaken: s_head.bptaken};
                s_rd_d  = ptr_inc(s_rd_q);
                if (ic_resp_error) begin
                    state_d = ST_HALT;
                end
            end else if (misalign_push) begin
                q_push  = 1'b1;
                q_wdata = '{error: 1'b1, addr: pc_q, insn: 32'd0, bptag: 16'd0, bptaken: 1'b0};
                state_d = ST_HALT;
            end

            out_d = out_q + CNTW'(ic_fire) - CNTW'(resp_take);
            if (q_push) begin
                q_wr_d = ptr_inc(q_wr_q);
            end
            if (de_pop) begin
                q_rd_d = ptr_inc(q_rd_q);
            end
            count_d = count_q + CNTW'(q_push) - CNTW'(de_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC[31:1];
            count_q <= '0;
            out_q   <= '0;
            drop_q  <= '0;
            q_rd_q  <= '0;
            q_wr_q  <= '0;
            s_rd_q  <= '0;
            s_wr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            q_rd_q  <= q_rd_d;
            q_wr_q  <= q_wr_d;
            s_rd_q  <= s_rd_d;
            s_wr_q  <= s_wr_d;
        end
    end

    // Storage is data only; validity comes from the counters and pointers.
    always_ff @(posedge clk) begin
        if (s_push) begin
            s_mem[s_wr_q] <= '{pc: pc_q, bptag: bp_tag, bptaken: bp_taken};
        end
        if (q_push) begin
            q_mem[q_wr_q] <= q_wdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(q_push && !de_pop && count_q == QFULL))
        else $error("fetch: instruction queue push while full");

    a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
        !(ic_resp_valid && out_q == '0 && drop_q == '0))
        else $error("fetch: cache response with nothing outstanding");

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: cache and predictor models driven per cycle, with
// hand-computed expected request and decode streams.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_ic_req;
    logic [29:0] fetch_ic_addr;
    logic        ic_ready = 1'b1;
    logic        ic_resp_valid = 1'b0;
    logic [31:0] ic_resp_insn = '0;
    logic        ic_resp_error = 1'b0;
    logic [29:0] fetch_bp_addr;
    logic        bp_taken = 1'b0;
    logic [15:0] bp_tag = '0;
    logic [30:0] bp_target = '0;
    logic        fetch_de_valid;
    logic        fetch_de_error;
    logic [30:0] fetch_de_addr;
    logic [31:0] fetch_de_insn;
    logic [15:0] fetch_de_bptag;
    logic        fetch_de_bptaken;
    logic        decode_stall = 1'b0;
    logic        rob_flush = 1'b0;
    logic [30:0] rob_flush_pc = '0;

    fetch #(.RESET_PC(32'h0000_1000), .QDEPTH(4), .CNTW(3)) dut (
        .clk(clk), .rst(rst),
        .fetch_ic_req(fetch_ic_req), .fetch_ic_addr(fetch_ic_addr), .ic_ready(ic_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_insn(ic_resp_insn), .ic_resp_error(ic_resp_error),
        .fetch_bp_addr(fetch_bp_addr), .bp_taken(bp_taken), .bp_tag(bp_tag), .bp_target(bp_target),
        .fetch_de_valid(fetch_de_valid), .fetch_de_error(fetch_de_error), .fetch_de_addr(fetch_de_addr),
        .fetch_de_insn(fetch_de_insn), .fetch_de_bptag(fetch_de_bptag), .fetch_de_bptaken(fetch_de_bptaken),
        .decode_stall(decode_stall), .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [30:0] addr;
        logic [31:0] insn;
        logic [15:0] tag;
        logic        tk;
    } ent_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    logic        bp_en = 1'b0;
    logic [29:0] bp_word = '0;
    logic [30:0] bp_tgt = '0;
    logic        err_en = 1'b0;
    logic [29:0] err_word = '0;

    logic [29:0] pend_addr [$];
    int          pend_due [$];
    logic [29:0] req_log [$];
    ent_t        de_log [$];
    int          pop_cyc [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t ent_at(input int i);
        if (i < de_log.size()) return de_log[i];
        return '0;
    endfunction

    function automatic logic [31:0] req_byte(input int i);
        if (i < req_log.size()) return {req_log[i], 2'b00};
        return 32'hFFFF_FFFF;
    endfunction

    // One clock: drive cache response and predictor, sample handshakes, advance.
    task automatic tick();
        logic [29:0] a;
        int          d;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            a = pend_addr.pop_front();
            d = pend_due.pop_front();
            ic_resp_valid = 1'b1;
            ic_resp_insn  = {a, 2'b11};
            ic_resp_error = err_en && (a == err_word);
        end else begin
            ic_resp_valid = 1'b0;
            ic_resp_insn  = '0;
            ic_resp_error = 1'b0;
        end
        if (bp_en && fetch_bp_addr == bp_word) begin
            bp_taken  = 1'b1;
            bp_target = bp_tgt;
            bp_tag    = 16'hBEEF;
        end else begin
            bp_taken  = 1'b0;
            bp_target = '0;
            bp_tag    = 16'h0000;
        end
        #1;
        if (fetch_ic_req && ic_ready) begin
            req_log.push_back(fetch_ic_addr);
            pend_addr.push_back(fetch_ic_addr);
            pend_due.push_back(cyc + lat);
        end
        if (fetch_de_valid && !decode_stall) begin
            de_log.push_back('{err: fetch_de_error, addr: fetch_de_addr, insn: fetch_de_insn,
                               tag: fetch_de_bptag, tk: fetch_de_bptaken});
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        rob_flush = 1'b0;
        decode_stall = 1'b0;
        ic_resp_valid = 1'b0;
        ic_resp_insn = '0;
        ic_resp_error = 1'b0;
        bp_taken = 1'b0;
        bp_tag = '0;
        bp_target = '0;
        bp_en = 1'b0;
        err_en = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        req_log.delete();
        de_log.delete();
        pop_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_rst_req"}, fetch_ic_req, 0);
        check({tag, "_rst_icaddr"}, fetch_ic_addr, 30'h400);
        check({tag, "_rst_bpaddr"}, fetch_bp_addr, 30'h400);
        check({tag, "_rst_devalid"}, fetch_de_valid, 0);
        check({tag, "_rst_deaddr"}, fetch_de_addr, 0);
        rst = 1'b1;
        cyc = 0;
    endtask

    int maxd;
    int d;

    initial begin
        // Sequential fetch, L=1, no stall
        lat = 1;
        do_reset("seq");
        run(8);
        check("seq_req0", req_byte(0), 32'h1000);
        check("seq_req1", req_byte(1), 32'h1004);
        check("seq_req2", req_byte(2), 32'h1008);
        check("seq_de0_addr", ent_at(0).addr, 31'h800);
        check("seq_de1_addr", ent_at(1).addr, 31'h802);
        check("seq_de2_addr", ent_at(2).addr, 31'h804);
        check("seq_de0_insn", ent_at(0).insn, 32'h1003);
        check("seq_pop0_cyc", (pop_cyc.size() > 0) ? pop_cyc[0] : -1, 2);
        check("seq_pop1_cyc", (pop_cyc.size() > 1) ? pop_cyc[1] : -1, 3);
        check("seq_pop2_cyc", (pop_cyc.size() > 2) ? pop_cyc[2] : -1, 4);

        // Predicted taken branch at 0x1004 -> 0x2000
        do_reset("bp");
        bp_en = 1'b1;
        bp_word = 30'h401;
        bp_tgt = 31'h1000;
        run(8);
        check("bp_req2", req_byte(2), 32'h2000);
        check("bp_req3", req_byte(3), 32'h2004);
        check("bp_de0_tk", ent_at(0).tk, 0);
        check("bp_de0_tag", ent_at(0).tag, 16'h0000);
        check("bp_de1_addr", ent_at(1).addr, 31'h802);
        check("bp_de1_tk", ent_at(1).tk, 1);
        check("bp_de1_tag", ent_at(1).tag, 16'hBEEF);
        check("bp_de2_addr", ent_at(2).addr, 31'h1000);

        // Decode stall for 10 cycles: credit limit, then ordered drain
        do_reset("stall");
        run(3);
        decode_stall = 1'b1;
        maxd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            d = req_log.size() - de_log.size();
            if (d > maxd) maxd = d;
        end
        check("stall_max_inflight", maxd, 4);
        check("stall_req_low", fetch_ic_req, 0);
        check("stall_head_hold", fetch_de_addr, 31'h802);
        check("stall_valid", fetch_de_valid, 1);
        decode_stall = 1'b0;
        run(12);
        check("stall_enough_pops", de_log.size() >= 10, 1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_order%0d", i), ent_at(i).addr, 31'h800 + 31'(2 * i));
        end

        // Flush with two requests in flight, L=3
        lat = 3;
        do_reset("flush");
        run(2);
        rob_flush = 1'b1;
        rob_flush_pc = 31'h1800;
        #1;
        check("flush_no_req", fetch_ic_req, 0);
        tick();
        rob_flush = 1'b0;
        run(10);
        check("flush_req2", req_byte(2), 32'h3000);
        check("flush_de0_addr", ent_at(0).addr, 31'h1800);
        check("flush_de0_insn", ent_at(0).insn, 32'h3003);
        check("flush_de1_addr", ent_at(1).addr, 31'h1802);

        // Access fault on 0x1008, then halt
        lat = 1;
        do_reset("err");
        err_en = 1'b1;
        err_word = 30'h402;
        run(10);
        check("err_nreq", req_log.size(), 4);
        check("err_de1_err", ent_at(1).err, 0);
        check("err_de2_addr", ent_at(2).addr, 31'h804);
        check("err_de2_err", ent_at(2).err, 1);
        check("err_de3_addr", ent_at(3).addr, 31'h806);
        check("err_halt_req", fetch_ic_req, 0);

        // Redirect to misaligned 0x4002: single error entry, still halted
        rob_flush = 1'b1;
        rob_flush_pc = 31'h2001;
        tick();
        rob_flush = 1'b0;
        run(5);
        check("mis_nreq", req_log.size(), 4);
        check("mis_nde", de_log.size(), 5);
        check("mis_addr", ent_at(4).addr, 31'h2001);
        check("mis_err", ent_at(4).err, 1);
        check("mis_insn", ent_at(4).insn, 0);
        check("mis_tk", ent_at(4).tk, 0);
        check("mis_icaddr", fetch_ic_addr, 30'h1000);

        // Restart at 0x5000, then asynchronous reset mid-burst
        rob_flush = 1'b1;
        rob_flush_pc = 31'h2800;
        tick();
        rob_flush = 1'b0;
        run(3);
        check("burst_req", req_byte(4), 32'h5000);
        #2;
        rst = 1'b0;
        ic_resp_valid = 1'b0;
        #1;
        check("arst_req", fetch_ic_req, 0);
        check("arst_icaddr", fetch_ic_addr, 30'h400);
        check("arst_bpaddr", fetch_bp_addr, 30'h400);
        check("arst_devalid", fetch_de_valid, 0);
        check("arst_deaddr", fetch_de_addr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
